// File: rtl/axi4_lite_sdp_ram_bridge_pkg.sv
// Shared types and constants for the AXI4-Lite to simple dual-port RAM bridge.
// Optional feature macro: AXI4_LITE_SDP_RAM_BRIDGE_RANGE_CHECK_EN (address range check).
package axi4_lite_sdp_ram_bridge_pkg;

   typedef enum logic [1:0] {
      W_IDLE   = 2'd0,
      W_COMMIT = 2'd1,
      W_RESP   = 2'd2
   } wr_state_e;

   typedef enum logic [1:0] {
      R_IDLE  = 2'd0,
      R_ADDR  = 2'd1,
      R_LATCH = 2'd2,
      R_RESP  = 2'd3
   } rd_state_e;

   localparam logic [1:0] RESP_OKAY   = 2'b00;
   localparam logic [1:0] RESP_SLVERR = 2'b10;

endpackage

// File: rtl/axi4_lite_sdp_ram_bridge_wr.sv
// Write path: AW/W capture in any order, one-cycle RAM commit, then B response.
// Handshakes: a transfer happens on a rising edge where valid and ready are both
// high; once bvalid is high it and bresp stay stable until bready.
// With AXI4_LITE_SDP_RAM_BRIDGE_RANGE_CHECK_EN defined, writes with nonzero
// address bits above the RAM range are dropped and answered with SLVERR.
module axi4_lite_sdp_ram_bridge_wr
   import axi4_lite_sdp_ram_bridge_pkg::*;
#(
   parameter int AW = 32,
   parameter int A  = 6,
   parameter int N  = 4
) (
   input  logic            clk,
   input  logic            reset,
   input  logic [AW-1:0]   s_awaddr,
   input  logic            s_awvalid,
   output logic            s_awready,
   input  logic [8*N-1:0]  s_wdata,
   input  logic [N-1:0]    s_wstrb,
   input  logic            s_wvalid,
   output logic            s_wready,
   output logic [1:0]      s_bresp,
   output logic            s_bvalid,
   input  logic            s_bready,
   output logic            ram_we,
   output logic [A-1:0]    ram_waddr,
   output logic [N-1:0]    ram_be,
   output logic [8*N-1:0]  ram_wdata,
   output wr_state_e       o_state
);

   localparam int L = $clog2(N);

   wr_state_e        r_state;
   logic             r_aw_held;
   logic             r_w_held;
   logic [A-1:0]     r_waddr;
   logic             r_aw_oor;
   logic [8*N-1:0]   r_wdata;
   logic [N-1:0]     r_wstrb;
   logic             r_bvalid;
   logic [1:0]       r_bresp;

   logic             w_aw_hs;
   logic             w_w_hs;
   logic             w_aw_oor;
   logic             w_unused_addr;

   assign s_awready = (r_state == W_IDLE) && !r_aw_held;
   assign s_wready  = (r_state == W_IDLE) && !r_w_held;
   assign w_aw_hs   = s_awvalid && s_awready;
   assign w_w_hs    = s_wvalid && s_wready;

`ifdef AXI4_LITE_SDP_RAM_BRIDGE_RANGE_CHECK_EN
   assign w_aw_oor = (s_awaddr[AW-1:A+L] != '0);
`else
   assign w_aw_oor = 1'b0;
`endif
   // Byte-lane bits (and upper bits when the range check is off) do not select a word.
   assign w_unused_addr = ^{s_awaddr[AW-1:A+L], s_awaddr[L-1:0]};

   // RAM write port comes straight from the held registers; strobe only in W_COMMIT.
   assign ram_we    = (r_state == W_COMMIT) && !r_aw_oor;
   assign ram_waddr = r_waddr;
   assign ram_be    = r_wstrb;
   assign ram_wdata = r_wdata;
   assign s_bvalid  = r_bvalid;
   assign s_bresp   = r_bresp;
   assign o_state   = r_state;

   // Write FSM: collect AW and W, commit once, hold B until accepted.
   always_ff @(posedge clk) begin
      if (reset) begin
         r_state   <= W_IDLE;
         r_aw_held <= 1'b0;
         r_w_held  <= 1'b0;
         r_waddr   <= '0;
         r_aw_oor  <= 1'b0;
         r_wdata   <= '0;
         r_wstrb   <= '0;
         r_bvalid  <= 1'b0;
         r_bresp   <= RESP_OKAY;
      end else begin
         case (r_state)
            W_IDLE: begin
               if (w_aw_hs) begin
                  r_waddr   <= s_awaddr[A+L-1:L];
                  r_aw_oor  <= w_aw_oor;
                  r_aw_held <= 1'b1;
               end
               if (w_w_hs) begin
                  r_wdata  <= s_wdata;
                  r_wstrb  <= s_wstrb;
                  r_w_held <= 1'b1;
               end
               if ((r_aw_held || w_aw_hs) && (r_w_held || w_w_hs)) begin
                  r_state <= W_COMMIT;
               end
            end
            W_COMMIT: begin
               r_state  <= W_RESP;
               r_bvalid <= 1'b1;
               r_bresp  <= r_aw_oor ? RESP_SLVERR : RESP_OKAY;
            end
            W_RESP: begin
               if (s_bready) begin
                  r_bvalid  <= 1'b0;
                  r_aw_held <= 1'b0;
                  r_w_held  <= 1'b0;
                  r_state   <= W_IDLE;
               end
            end
            default: r_state <= W_IDLE;
         endcase
      end
   end

endmodule

// File: rtl/axi4_lite_sdp_ram_bridge.sv
// AXI4-Lite slave front end for a byte-enabled simple dual-port RAM.
// Write path lives in axi4_lite_sdp_ram_bridge_wr; the read FSM is here.
// Handshakes: a transfer happens on a rising edge where valid and ready are both
// high; once rvalid is high it, rdata and rresp stay stable until rready.
// With AXI4_LITE_SDP_RAM_BRIDGE_RANGE_CHECK_EN defined, out-of-range reads
// return zero data with SLVERR; otherwise upper address bits alias.
module axi4_lite_sdp_ram_bridge
   import axi4_lite_sdp_ram_bridge_pkg::*;
#(
   parameter int AW = 32,
   parameter int A  = 6,
   parameter int N  = 4
) (
   input  logic            clk,
   input  logic            reset,
   input  logic [AW-1:0]   s_awaddr,
   input  logic            s_awvalid,
   output logic            s_awready,
   input  logic [8*N-1:0]  s_wdata,
   input  logic [N-1:0]    s_wstrb,
   input  logic            s_wvalid,
   output logic            s_wready,
   output logic [1:0]      s_bresp,
   output logic            s_bvalid,
   input  logic            s_bready,
   input  logic [AW-1:0]   s_araddr,
   input  logic            s_arvalid,
   output logic            s_arready,
   output logic [8*N-1:0]  s_rdata,
   output logic [1:0]      s_rresp,
   output logic            s_rvalid,
   input  logic            s_rready,
   output logic            ram_we,
   output logic [A-1:0]    ram_waddr,
   output logic [N-1:0]    ram_be,
   output logic [8*N-1:0]  ram_wdata,
   output logic [A-1:0]    ram_raddr,
   input  logic [8*N-1:0]  ram_q,
   output logic [1:0]      o_wr_state,
   output logic [1:0]      o_rd_state
);

   localparam int L = $clog2(N);

   wr_state_e        w_wr_state;
   rd_state_e        r_rstate;
   logic [A-1:0]     r_raddr;
   logic             r_rd_oor;
   logic [8*N-1:0]   r_rdata;
   logic [1:0]       r_rresp;
   logic             r_rvalid;

   logic             w_ar_oor;
   logic             w_unused_addr;

   axi4_lite_sdp_ram_bridge_wr #(.AW(AW), .A(A), .N(N)) u_wr (
      .clk       (clk),
      .reset     (reset),
      .s_awaddr  (s_awaddr),
      .s_awvalid (s_awvalid),
      .s_awready (s_awready),
      .s_wdata   (s_wdata),
      .s_wstrb   (s_wstrb),
      .s_wvalid  (s_wvalid),
      .s_wready  (s_wready),
      .s_bresp   (s_bresp),
      .s_bvalid  (s_bvalid),
      .s_bready  (s_bready),
      .ram_we    (ram_we),
      .ram_waddr (ram_waddr),
      .ram_be    (ram_be),
      .ram_wdata (ram_wdata),
      .o_state   (w_wr_state)
   );

`ifdef AXI4_LITE_SDP_RAM_BRIDGE_RANGE_CHECK_EN
   assign w_ar_oor = (s_araddr[AW-1:A+L] != '0);
`else
   assign w_ar_oor = 1'b0;
`endif
   // Byte-lane bits (and upper bits when the range check is off) do not select a word.
   assign w_unused_addr = ^{s_araddr[AW-1:A+L], s_araddr[L-1:0]};

   assign s_arready  = (r_rstate == R_IDLE);
   assign s_rvalid   = r_rvalid;
   assign s_rdata    = r_rdata;
   assign s_rresp    = r_rresp;
   assign ram_raddr  = r_raddr;
   assign o_wr_state = w_wr_state;
   assign o_rd_state = r_rstate;

   // Read FSM: present address, wait out the RAM latency, capture q, hold R.
   always_ff @(posedge clk) begin
      if (reset) begin
         r_rstate <= R_IDLE;
         r_raddr  <= '0;
         r_rd_oor <= 1'b0;
         r_rdata  <= '0;
         r_rresp  <= RESP_OKAY;
         r_rvalid <= 1'b0;
      end else begin
         case (r_rstate)
            R_IDLE: begin
               if (s_arvalid) begin
                  r_raddr  <= s_araddr[A+L-1:L];
                  r_rd_oor <= w_ar_oor;
                  r_rstate <= R_ADDR;
               end
            end
            R_ADDR: r_rstate <= R_LATCH;
            R_LATCH: begin
               r_rdata  <= r_rd_oor ? '0 : ram_q;
               r_rresp  <= r_rd_oor ? RESP_SLVERR : RESP_OKAY;
               r_rvalid <= 1'b1;
               r_rstate <= R_RESP;
            end
            R_RESP: begin
               if (s_rready) begin
                  r_rvalid <= 1'b0;
                  r_rstate <= R_IDLE;
               end
            end
            default: r_rstate <= R_IDLE;
         endcase
      end
   end

endmodule
